// File: rtl/latch_load_arbiter.sv
// latch_load_arbiter: round-robin arbiter and load sequencer for a shared
// level-sensitive data latch. It grants one requester at a time, drives the
// latch data and load enable for a fixed hold time, and then pulses done.
// Requests and request data are registered on entry. A request therefore
// turns into a grant one edge after it is first sampled, and the captured
// data always belongs to the same sample as the request that won.
module latch_load_arbiter #(
  parameter int NREQ        = 4,
  parameter int DW          = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     load,
  output logic [DW-1:0]            data_out,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RELEASE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [NREQ-1:0]   req_q;
  logic [NREQ*DW-1:0] req_data_q;
  logic [OW-1:0]     ptr;
  logic [OW-1:0]     ptr_next;
  logic [OW-1:0]     owner_next;
  logic [OW-1:0]     win;
  logic              found;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_next;
  logic [NREQ-1:0]   gnt_next;
  logic [NREQ-1:0]   done_next;
  logic              load_next;
  logic [DW-1:0]     data_next;

  // Position k of the circular search that starts at the priority pointer.
  function automatic logic [OW-1:0] rr_index(input logic [OW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return OW'(s);
  endfunction

  // Round-robin winner: the first registered request found from ptr upward.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_q[rr_index(ptr, k)]) begin
        found = 1'b1;
        win   = rr_index(ptr, k);
      end
    end
  end

  // Next-state and next-output logic; every register holds unless a phase changes it.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ptr_next   = ptr;
    gnt_next   = gnt;
    load_next  = load;
    done_next  = '0;
    owner_next = owner;
    data_next  = data_out;
    case (state)
      IDLE: begin
        if (found) begin
          state_next = LOAD;
          data_next  = req_data_q[win*DW +: DW];
          owner_next = win;
          gnt_next   = NREQ'(1) << win;
          load_next  = 1'b1;
          cnt_next   = CW'(HOLD_CYCLES - 1);
          ptr_next   = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
        end
      end
      LOAD: begin
        if (cnt == '0) begin
          state_next = RELEASE;
          load_next  = 1'b0;
          gnt_next   = '0;
          done_next  = gnt;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, outputs and input sampling registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= '0;
      gnt        <= '0;
      load       <= 1'b0;
      done       <= '0;
      owner      <= '0;
      data_out   <= '0;
      req_q      <= '0;
      req_data_q <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      ptr        <= ptr_next;
      gnt        <= gnt_next;
      load       <= load_next;
      done       <= done_next;
      owner      <= owner_next;
      data_out   <= data_next;
      req_q      <= req;
      req_data_q <= req_data;
    end
  end

  // Busy covers both the LOAD and RELEASE phases.
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_latch_load_arbiter.sv
// tb_latch_load_arbiter: stimulus pushes predicted grants into a scoreboard
// queue, and an independent monitor pops and compares them as the DUT loads.
module tb_latch_load_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int HOLD = 2;

  typedef struct packed {
    logic [31:0] idx;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        load;
  logic [7:0]  data_out;
  logic [1:0]  owner;
  logic        busy;

  exp_t exp_q[$];
  exp_t mon_item;
  int   check_count = 0;
  int   pass_count  = 0;
  int   model_ptr   = 0;
  logic [7:0] last_data = 8'h00;
  int   load_run    = 0;
  int   gap_run     = 99;
  logic prev_load   = 1'b0;
  logic [3:0] done_seen;

  latch_load_arbiter #(.NREQ(NREQ), .DW(DW), .HOLD_CYCLES(HOLD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .load     (load),
    .data_out (data_out),
    .owner    (owner),
    .busy     (busy)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Reference model: serve the set requesters in circular order from the pointer,
  // then issue the requests and play the requester side until all grants are done.
  task automatic applyStimulus(input logic [3:0] mask, input int hold_grants, input bit chaos);
    logic [7:0] d[4];
    logic [3:0] remaining;
    int n;
    int dones;
    int cyc;
    int pick;
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    remaining = mask;
    n = (hold_grants > 0) ? hold_grants : $countones(mask);
    for (int g = 0; g < n; g++) begin
      pick = -1;
      for (int k = 0; k < 4; k++)
        if (pick < 0 && remaining[(model_ptr + k) % 4]) pick = (model_ptr + k) % 4;
      e.idx  = 32'(pick);
      e.data = d[pick];
      exp_q.push_back(e);
      last_data = d[pick];
      model_ptr = (pick + 1) % 4;
      if (hold_grants == 0) remaining[pick] = 1'b0;
    end
    req_data = {d[3], d[2], d[1], d[0]};
    req      = mask;
    dones = 0;
    cyc   = 0;
    while (!(dones == n && busy == 1'b0) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done != 4'b0000) begin
        dones++;
        if (hold_grants == 0) req = req & ~done;
        else if (dones == hold_grants) req = 4'b0000;
      end else if (chaos && load && $urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++)
          if (gnt[i]) req_data[i*8 +: 8] = ~d[i];
        if ($urandom_range(0, 1) == 1) req = req & ~gnt;
      end
    end
    if (cyc >= 100) checkOutput("txn_timeout_cycles", 32'(cyc), 32'd0);
    else checkOutput("idle_data_out_kept", 32'(data_out), 32'(last_data));
  endtask

  // Scoreboard monitor: checks each grant as load rises and each done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      load_run  = 0;
      gap_run   = 99;
      prev_load = 1'b0;
    end else begin
      if (load) begin
        if (!prev_load) begin
          checkOutput("load_gap_at_least_2", 32'(gap_run >= 2), 32'd1);
          if (exp_q.size() == 0) checkOutput("grant_unexpected", 32'(gnt), 32'd0);
          else begin
            checkOutput("grant_vec", 32'(gnt), 32'd1 << exp_q[0].idx);
            checkOutput("grant_owner", 32'(owner), exp_q[0].idx);
            checkOutput("grant_data", 32'(data_out), 32'(exp_q[0].data));
          end
        end
        load_run++;
        gap_run = 0;
      end else begin
        gap_run++;
      end
      if (done != 4'b0000) begin
        if (exp_q.size() == 0) checkOutput("done_unexpected", 32'(done), 32'd0);
        else begin
          mon_item = exp_q.pop_front();
          checkOutput("done_vec", 32'(done), 32'd1 << mon_item.idx);
          checkOutput("done_data", 32'(data_out), 32'(mon_item.data));
          checkOutput("load_length", 32'(load_run), 32'(HOLD));
        end
        load_run = 0;
      end
      prev_load = load;
    end
  end

  // Main sequence: directed scenarios first, then randomized transactions.
  initial begin
    int cyc;
    int mode;
    rst_n    = 1'b1;
    req      = 4'b0000;
    req_data = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_outputs", {18'b0, gnt, done, load, data_out, owner, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_after_reset_busy", 32'(busy), 32'd0);
    checkOutput("idle_after_reset_load", 32'(load), 32'd0);

    // Single request timing, cycle by cycle.
    req_data[15:8] = 8'hA5;
    req = 4'b0010;
    mon_item.idx  = 32'd1;
    mon_item.data = 8'hA5;
    exp_q.push_back(mon_item);
    model_ptr = 2;
    last_data = 8'hA5;
    @(posedge clk); @(negedge clk);
    checkOutput("single_k_load", 32'(load), 32'd0);
    @(posedge clk); @(negedge clk);
    checkOutput("single_k1_state", {load, gnt, 2'b0, owner, data_out}, {1'b1, 4'b0010, 2'b0, 2'd1, 8'hA5});
    @(posedge clk); @(negedge clk);
    checkOutput("single_k2_load", 32'(load), 32'd1);
    @(posedge clk); @(negedge clk);
    checkOutput("single_k3_done", {load, done}, {1'b0, 4'b0010});
    req = 4'b0000;
    @(posedge clk); @(negedge clk);
    checkOutput("single_k4_idle", {busy, done}, 5'b0);

    // Wrap-around and alternation.
    applyStimulus(4'b0100, 0, 1'b0);
    applyStimulus(4'b1001, 0, 1'b0);
    applyStimulus(4'b0101, 6, 1'b0);
    applyStimulus(4'b0001, 0, 1'b1);

    // All four requesting from a fresh reset.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    applyStimulus(4'b1111, 0, 1'b0);

    // Reset in the second LOAD cycle aborts the grant without a done pulse.
    @(negedge clk);
    req_data[23:16] = 8'($urandom);
    mon_item.idx  = 32'd2;
    mon_item.data = req_data[23:16];
    exp_q.push_back(mon_item);
    req = 4'b0100;
    cyc = 0;
    while (!load && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("midgrant_load_seen", 32'(load), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midgrant_async_clear", {18'b0, gnt, done, load, data_out, owner, busy}, 32'd0);
    exp_q.delete();
    req = 4'b0000;
    done_seen = 4'b0000;
    repeat (2) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    rst_n = 1'b1;
    model_ptr = 0;
    repeat (3) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    checkOutput("midgrant_no_done", 32'(done_seen), 32'd0);
    applyStimulus(4'b1100, 0, 1'b0);

    // Randomized transactions.
    for (int t = 0; t < 25; t++) begin
      mode = $urandom_range(0, 3);
      if (mode == 0) applyStimulus(4'($urandom_range(1, 15)), $urandom_range(2, 5), 1'b0);
      else applyStimulus(4'($urandom_range(1, 15)), 0, mode[0]);
    end

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
